// File: rtl/config_register_bank_pkg.sv
// Shared types and defaults for the configuration register bank.
// Holds the FSM state encoding, default constants and width helpers.
package config_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_LOCK   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_WAIT   = ST_WAIT,
    S_COMMIT = ST_COMMIT,
    S_LOCK   = ST_LOCK
  } state_t;

  localparam int unsigned DEF_DATA_W      = 7;
  localparam int unsigned DEF_KEY_W       = 8;
  localparam logic [7:0]  DEF_KEY         = 8'hC0;
  localparam int unsigned DEF_CH          = 4;
  localparam int unsigned DEF_MAX_FAIL    = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

  // inputData MSB picks the target register: 0 = P, 1 = Q
  function automatic int unsigned sel_bit(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned chan_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/config_register_bank_if.sv
// Operator-side bus of the configuration register bank.
interface config_register_bank_if
  import config_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned KEY_W  = DEF_KEY_W,
  parameter int unsigned CH     = DEF_CH
);
  localparam int unsigned CHW = chan_w(CH);

  logic                 request;
  logic                 confirm;
  logic [KEY_W-1:0]     key;
  logic [CHW-1:0]       channel;
  logic [DATA_W:0]      inputData;
  logic [CH*DATA_W-1:0] dataP;
  logic [CH*DATA_W-1:0] dataQ;
  logic                 busy;
  logic                 ack;
  logic                 err;
  logic                 locked;

  modport master (
    output request, confirm, key, channel, inputData,
    input  dataP, dataQ, busy, ack, err, locked
  );

  modport slave (
    input  request, confirm, key, channel, inputData,
    output dataP, dataQ, busy, ack, err, locked
  );

endinterface

// File: rtl/config_register_bank_lockout.sv
// Consecutive bad-key counter and lockout timer.
module config_lockout #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic bad_key,
  input  logic clear,
  output logic locked,
  output logic lock_done
);
  localparam int unsigned FW = (MAX_FAIL > 1) ? $clog2(MAX_FAIL) : 1;
  localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [FW-1:0] fails;
  logic [TW-1:0] timer;
  logic          locked_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fails    <= '0;
      timer    <= '0;
      locked_q <= 1'b0;
    end else if (locked_q) begin
      if (timer == '0) begin
        locked_q <= 1'b0;
        fails    <= '0;
      end else begin
        timer <= timer - 1'b1;
      end
    end else if (clear) begin
      fails <= '0;
    end else if (bad_key) begin
      // timer counts down LOCK_CYCLES-1..0, giving LOCK_CYCLES locked cycles
      if (fails == FW'(MAX_FAIL - 1)) begin
        locked_q <= 1'b1;
        timer    <= TW'(LOCK_CYCLES - 1);
        fails    <= '0;
      end else begin
        fails <= fails + 1'b1;
      end
    end
  end

  assign locked    = locked_q;
  assign lock_done = locked_q && (timer == '0);

endmodule

// File: rtl/config_register_bank.sv
// Multi-channel P/Q threshold bank behind a key-authenticated request/confirm handshake.
// Optional CONFIG_RANGE_CHECK_EN rejects writes that would leave P > Q on a channel.
module config_register_bank
  import config_pkg::*;
#(
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       KEY_W       = DEF_KEY_W,
  parameter logic [KEY_W-1:0]  KEY         = KEY_W'(DEF_KEY),
  parameter int unsigned       CH          = DEF_CH,
  parameter int unsigned       MAX_FAIL    = DEF_MAX_FAIL,
  parameter int unsigned       LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input logic                   clock,
  input logic                   reset,
  config_register_bank_if.slave bus
);
  localparam int unsigned CHW = chan_w(CH);
  localparam int unsigned SEL = sel_bit(DATA_W);

  state_t               state;
  logic                 armed;
  logic [CHW-1:0]       ch_q;
  logic [DATA_W:0]      din_q;
  logic [CH*DATA_W-1:0] p_q;
  logic [CH*DATA_W-1:0] q_q;
  logic                 ack_q;
  logic                 err_q;
  logic                 lk_locked;
  logic                 lk_done;
  logic                 start;
  logic                 key_ok;
  logic                 bad_key;
  logic                 clr_fail;
  logic                 ch_ok;
  logic                 reject;
  logic [DATA_W-1:0]    val;
`ifdef CONFIG_RANGE_CHECK_EN
  logic [DATA_W-1:0]    p_cur;
  logic [DATA_W-1:0]    q_cur;
`endif

  config_lockout #(
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lockout (
    .clock     (clock),
    .reset     (reset),
    .bad_key   (bad_key),
    .clear     (clr_fail),
    .locked    (lk_locked),
    .lock_done (lk_done)
  );

  always_comb begin
    start    = (state == S_IDLE) && !lk_locked && bus.request && armed;
    key_ok   = (bus.key == KEY);
    bad_key  = start && !key_ok;
    clr_fail = start && key_ok;
    ch_ok    = (32'(ch_q) < CH);
    val      = din_q[DATA_W-1:0];
    reject   = !ch_ok;
`ifdef CONFIG_RANGE_CHECK_EN
    p_cur = '0;
    q_cur = '0;
    if (ch_ok) begin
      p_cur = p_q[ch_q*DATA_W +: DATA_W];
      q_cur = q_q[ch_q*DATA_W +: DATA_W];
      reject = din_q[SEL] ? (p_cur > val) : (val > q_cur);
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      armed <= 1'b1;
      ch_q  <= '0;
      din_q <= '0;
      p_q   <= '0;
      q_q   <= '1;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (state != S_LOCK && !lk_locked && !bus.request)
        armed <= 1'b1;
      case (state)
        S_IDLE: begin
          // lockout asserts one cycle before the FSM reaches LOCK; inputs are gated meanwhile
          if (lk_locked) begin
            state <= lk_done ? S_IDLE : S_LOCK;
          end else if (start) begin
            armed <= 1'b0;
            if (key_ok) state <= S_WAIT;
            else        err_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.request) begin
            state <= S_IDLE;
          end else if (bus.confirm) begin
            ch_q  <= bus.channel;
            din_q <= bus.inputData;
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          state <= S_IDLE;
          if (reject) begin
            err_q <= 1'b1;
          end else begin
            ack_q <= 1'b1;
            if (din_q[SEL]) q_q[ch_q*DATA_W +: DATA_W] <= val;
            else            p_q[ch_q*DATA_W +: DATA_W] <= val;
          end
        end
        S_LOCK:  if (lk_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dataP  = p_q;
  assign bus.dataQ  = q_q;
  assign bus.busy   = (state == S_WAIT) || (state == S_COMMIT);
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.locked = lk_locked;

endmodule

// File: tb/tb_config_register_bank.sv
// Self-checking bench for config_register_bank (CH=3 so an out-of-range channel exists).
module tb_config_register_bank;
  localparam int unsigned NCH = 3;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fail_cnt;
  logic [6:0] mp [NCH];
  logic [6:0] mq [NCH];

  typedef struct {
    logic [7:0] key;
    logic [1:0] ch;
    logic [7:0] data;
    logic       ack;
    logic       err;
    logic       chk_val;
    logic [6:0] val;
  } vec_t;
  vec_t tbl [7];

  config_register_bank_if #(.DATA_W(7), .KEY_W(8), .CH(NCH)) ifc ();

  config_register_bank #(
    .DATA_W(7), .KEY_W(8), .KEY(8'hC0), .CH(NCH), .MAX_FAIL(3), .LOCK_CYCLES(16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mp[i] = '0;
      mq[i] = '1;
    end
    fail_cnt = 0;
  endtask

  // Returns 1 when the write must be refused
  function automatic bit model_write(input logic [1:0] c, input logic [7:0] d);
    if (int'(c) >= NCH) return 1'b1;
    if (d[7]) begin
`ifdef CONFIG_RANGE_CHECK_EN
      if (mp[c] > d[6:0]) return 1'b1;
`endif
      mq[c] = d[6:0];
    end else begin
`ifdef CONFIG_RANGE_CHECK_EN
      if (d[6:0] > mq[c]) return 1'b1;
`endif
      mp[c] = d[6:0];
    end
    return 1'b0;
  endfunction

  function automatic logic [6:0] reg_of(input logic [1:0] c, input logic sel);
    return sel ? 7'(ifc.dataQ >> (c * 7)) : 7'(ifc.dataP >> (c * 7));
  endfunction

  task automatic chk_regs();
    logic [20:0] ep, eq;
    for (int i = 0; i < NCH; i++) begin
      ep[i*7 +: 7] = mp[i];
      eq[i*7 +: 7] = mq[i];
    end
    chk("dataP", ifc.dataP, ep);
    chk("dataQ", ifc.dataQ, eq);
  endtask

  task automatic wait_lock(input bit poke);
    int n;
    bit noisy;
    n = 1;
    noisy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      ifc.request = poke && (i >= 4) && (i < 8);
      ifc.key     = 8'hC0;
      ifc.confirm = poke && (i == 6);
      @(posedge clock); #1;
      if (!ifc.locked) break;
      n++;
      if (ifc.busy || ifc.ack || ifc.err) noisy = 1;
    end
    ifc.confirm = 1'b0;
    chk("lock_len", n, 16);
    chk("lock_quiet", noisy, 0);
    fail_cnt = 0;
  endtask

  task automatic txn(input logic [7:0] k, input logic [1:0] c, input logic [7:0] d,
                     input bit poke, output logic got_ack, output logic got_err);
    bit exp_err;
    @(negedge clock);
    ifc.request = 1'b1;
    ifc.key     = k;
    ifc.confirm = 1'b0;
    @(posedge clock); #1;
    if (k == 8'hC0) begin
      fail_cnt = 0;
      chk("wait_busy", ifc.busy, 1);
      chk("wait_err", ifc.err, 0);
      @(negedge clock);
      ifc.confirm   = 1'b1;
      ifc.channel   = c;
      ifc.inputData = d;
      @(posedge clock); #1;
      chk("commit_busy", ifc.busy, 1);
      chk("commit_ack", ifc.ack, 0);
      @(negedge clock);
      ifc.confirm = 1'b0;
      @(posedge clock); #1;
      exp_err = model_write(c, d);
      got_ack = ifc.ack;
      got_err = ifc.err;
      chk("ack", ifc.ack, !exp_err);
      chk("err", ifc.err, exp_err);
      chk("done_busy", ifc.busy, 0);
    end else begin
      fail_cnt++;
      got_ack = ifc.ack;
      got_err = ifc.err;
      chk("badkey_err", ifc.err, 1);
      chk("badkey_busy", ifc.busy, 0);
      chk("badkey_locked", ifc.locked, 64'(fail_cnt == 3));
      if (fail_cnt == 3) wait_lock(poke);
    end
    chk_regs();
    @(negedge clock);
    ifc.request = 1'b0;
    @(posedge clock); #1;
    chk("idle_quiet", {ifc.ack, ifc.err, ifc.busy}, 0);
  endtask

  initial begin
    logic a, e;
    int errs;

    tbl[0] = '{8'hC0, 2'd2, 8'h25, 1'b1, 1'b0, 1'b1, 7'h25};
    tbl[1] = '{8'hC0, 2'd0, 8'hC0, 1'b1, 1'b0, 1'b1, 7'h40};
    tbl[2] = '{8'hC0, 2'd1, 8'h90, 1'b1, 1'b0, 1'b1, 7'h10};
`ifdef CONFIG_RANGE_CHECK_EN
    tbl[3] = '{8'hC0, 2'd1, 8'h20, 1'b0, 1'b1, 1'b1, 7'h00};
`else
    tbl[3] = '{8'hC0, 2'd1, 8'h20, 1'b1, 1'b0, 1'b1, 7'h20};
`endif
    tbl[4] = '{8'hC0, 2'd3, 8'h55, 1'b0, 1'b1, 1'b0, 7'h00};
    tbl[5] = '{8'h11, 2'd0, 8'h05, 1'b0, 1'b1, 1'b1, 7'h00};
    tbl[6] = '{8'hC0, 2'd0, 8'h05, 1'b1, 1'b0, 1'b1, 7'h05};

    reset = 1'b1;
    ifc.request = 1'b0; ifc.confirm = 1'b0; ifc.key = '0;
    ifc.channel = '0;   ifc.inputData = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_dataP", ifc.dataP, 21'h0);
    chk("rst_dataQ", ifc.dataQ, 21'h1FFFFF);
    chk("rst_flags", {ifc.busy, ifc.ack, ifc.err, ifc.locked}, 0);

    for (int i = 0; i < 7; i++) begin
      txn(tbl[i].key, tbl[i].ch, tbl[i].data, 1'b0, a, e);
      chk($sformatf("tbl%0d_ack", i), a, tbl[i].ack);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].err);
      if (tbl[i].chk_val)
        chk($sformatf("tbl%0d_val", i), reg_of(tbl[i].ch, tbl[i].data[7]), tbl[i].val);
    end

    // abort in WAIT; confirm raised with request in IDLE counts as request only
    @(negedge clock);
    ifc.request = 1'b1; ifc.key = 8'hC0; ifc.confirm = 1'b1;
    ifc.channel = 2'd2; ifc.inputData = 8'h7F;
    @(posedge clock); #1;
    chk("abort_wait", ifc.busy, 1);
    @(negedge clock);
    ifc.request = 1'b0;
    @(posedge clock); #1;
    chk("abort_idle", {ifc.busy, ifc.ack, ifc.err}, 0);
    ifc.confirm = 1'b0;
    @(posedge clock); #1;
    chk("abort_quiet", {ifc.busy, ifc.ack, ifc.err}, 0);
    chk_regs();

    // held bad-key request is checked only once
    errs = 0;
    @(negedge clock);
    ifc.request = 1'b1; ifc.key = 8'h33;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (ifc.err) errs++;
    end
    chk("held_badkey_errs", errs, 1);
    chk("held_badkey_busy", ifc.busy, 0);
    fail_cnt++;
    @(negedge clock);
    ifc.request = 1'b0;
    @(posedge clock); #1;

    // clears the fail counter, then three bad keys lock; a good request during lock is ignored
    txn(8'hC0, 2'd2, 8'h0A, 1'b0, a, e);
    txn(8'h11, 2'd0, 8'h00, 1'b0, a, e);
    txn(8'h11, 2'd0, 8'h00, 1'b0, a, e);
    txn(8'h11, 2'd0, 8'h00, 1'b1, a, e);
    txn(8'hC0, 2'd1, 8'h03, 1'b0, a, e);
    chk("post_lock_ack", a, 1);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] k;
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hC0;
      txn(k, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0, a, e);
    end

    // reset while in COMMIT wins over the pending write
    @(negedge clock);
    ifc.request = 1'b1; ifc.key = 8'hC0;
    @(posedge clock); #1;
    @(negedge clock);
    ifc.confirm = 1'b1; ifc.channel = 2'd0; ifc.inputData = 8'h7E;
    @(posedge clock); #1;
    chk("pre_rst_commit", ifc.busy, 1);
    @(negedge clock);
    reset = 1'b1; ifc.confirm = 1'b0; ifc.request = 1'b0;
    @(posedge clock); #1;
    model_reset();
    chk("rst_commit_flags", {ifc.busy, ifc.ack, ifc.err, ifc.locked}, 0);
    chk_regs();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("after_rst_quiet", {ifc.busy, ifc.ack, ifc.err}, 0);
    chk_regs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/config_register_bank.md
# config_register_bank

Parametrised, multi-channel successor to the single-pair configuration unit. It holds CH independent pairs of threshold registers (P and Q) for the healthcare monitor. Each pair is written through a key-authenticated request/confirm handshake, with failed-key lockout and per-channel addressing. It sits between the operator input path and the alarm/comparison logic, which reads dataP/dataQ continuously.

## Interface
- DATA_W, 7, width of each P/Q threshold value
- KEY_W, 8, width of the access key
- KEY, 8'hC0, access key compared against `key`
- CH, 4, number of channels (≥1)
- MAX_FAIL, 3, consecutive bad keys before lockout
- LOCK_CYCLES, 16, lockout duration in clock cycles
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- request  in  1  level, held high for the whole transaction
- confirm  in  1  data-valid strobe, sampled only in WAIT
- key  in  KEY_W  access key, sampled in IDLE when request=1
- channel  in  max(1,$clog2(CH))  target channel, sampled with confirm
- inputData  in  DATA_W+1  MSB selects target (0=P, 1=Q), low DATA_W bits = value
- dataP  out  CH*DATA_W  packed P registers, channel i at [i*DATA_W +: DATA_W]
- dataQ  out  CH*DATA_W  packed Q registers, same packing
- busy  out  1  high in WAIT and COMMIT
- ack  out  1  one-cycle pulse after a completed write
- err  out  1  one-cycle pulse on bad key, bad channel or rejected write
- locked  out  1  high in LOCK

## Operation
- FSM states: IDLE, WAIT, COMMIT, LOCK.
- IDLE, request=1, key==KEY: go to WAIT and clear the fail counter.
- IDLE, request=1, key!=KEY: pulse err and increment the fail counter. When the counter reaches MAX_FAIL, go to LOCK; otherwise stay in IDLE.
- The key check happens once per request assertion. A mismatching request held high is not re-checked until it drops and rises again.
- WAIT, request=0: abort to IDLE, no write, no err.
- WAIT, confirm=1: latch channel and inputData, go to COMMIT.
- confirm is ignored in IDLE and LOCK. request and confirm high together in IDLE are treated as a request only.
- COMMIT: if channel ≥ CH, pulse err and skip the write. Otherwise write the selected register. Go to IDLE.
- Returning to IDLE with request still high does not start a new transaction until request drops.
- LOCK: count LOCK_CYCLES cycles with all inputs ignored. Then return to IDLE and clear the fail counter.
- Reset values: dataP all 0, dataQ all 1 (per channel), busy/ack/err/locked 0, state IDLE, fail counter 0.
- Reset mid-transaction or mid-lock drops the transaction and restores the reset values.

## Timing
- Key check: err or the WAIT entry is visible the cycle after the edge where request was sampled.
- Write latency:
  - edge N samples confirm, giving COMMIT in cycle N+1;
  - edge N+1 updates the register and raises ack;
  - the new value and ack are visible together during cycle N+2.
- ack and err are exactly one cycle wide. They are never high in the same cycle.
- Lockout entry: locked rises the cycle after the MAX_FAIL-th bad key and stays high for exactly LOCK_CYCLES cycles.

## Configuration
- CONFIG_RANGE_CHECK_EN defined: COMMIT rejects any write that would leave P > Q on that channel. A rejected write pulses err and leaves the register unchanged.
- CONFIG_RANGE_CHECK_EN undefined: every in-range-channel write is accepted unconditionally.

## Structure
- Shared package `config_pkg`: FSM state enum, the inputData target-select bit position, and default KEY/threshold constants.
- One sub-module, `config_lockout`: fail counter plus lock timer. Inputs are bad_key/clear; outputs are locked/lock_done.

## Test plan
- Reset, then request=1, key=8'hC0, confirm=1, channel=2, inputData=8'h25 → dataP[2]=7'h25 two cycles after confirm is sampled, ack pulse, other channels unchanged.
- Valid key, inputData=8'hC0 (Q, value 7'h40), channel=0 → dataQ[0]=7'h40, dataP[0] still 0, ack pulse.
- Three requests with key=8'h11 → three err pulses, locked=1 for 16 cycles, a correct-key request during lock is ignored, a correct-key request after lock succeeds.
- With CONFIG_RANGE_CHECK_EN: set Q[1]=7'h10, then write P[1]=7'h20 → err, dataP[1] stays 0. Without the macro, the same write gives dataP[1]=7'h20.
- request dropped in WAIT before confirm → return to IDLE, no ack/err, registers unchanged.
- With CH=3, write to channel=3 → err, no register changes. Reset asserted in COMMIT → all outputs at reset values the next cycle.
